icap_reboot_seq: RTL and testbench



---
 rtl/icap_reboot_seq.sv | 166 ++++++++++++++++
 tb/tb_icap_reboot_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_reboot_seq.sv
// -----------------------------------------------------------------------------
// icap_reboot_seq
//   Multiboot request sequencer for the Spartan-6 ZX-Uno. A raw core-switch
//   request is synchronised and width-filtered; once accepted, the block plays
//   the IPROG command stream into the ICAP_SPARTAN6 write port so the FPGA
//   reloads from the selected SPI flash address. The top level owns the ICAP
//   primitive and wires its CE/WRITE/I pins to the outputs below.
//
//   Build option: define ICAP_BITSWAP_EN to bit-reverse each byte of icap_o
//   (the ordering the ICAP primitive expects). Leave it undefined to see the
//   command words in their documented form, e.g. in simulation or on a logic
//   analyser. Sequencing is identical in both builds.
//
// Ports
//   clk        in   system clock (14 MHz in the top level), rising edge
//   rst_n      in   asynchronous active-low reset
//   reboot_req in   raw request level, asynchronous to clk
//   boot_addr  in   [23:0] multiboot start address, captured on acceptance
//   icap_ce_n  out  ICAP CE, active low
//   icap_we_n  out  ICAP WRITE, active low
//   icap_o     out  [15:0] ICAP data word
//   busy       out  high from acceptance until reset
// -----------------------------------------------------------------------------
module icap_reboot_seq #(
  parameter int          MIN_PULSE     = 4,
  parameter logic [7:0]  SPI_OPCODE    = 8'h0B,
  parameter logic [23:0] FALLBACK_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reboot_req,
  input  logic [23:0] boot_addr,
  output logic        icap_ce_n,
  output logic        icap_we_n,
  output logic [15:0] icap_o,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_CLOSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] MIN_CNT  = 4'(MIN_PULSE);
  localparam logic [3:0] LAST_IDX = 4'd13;

  logic        req_m;
  logic        req_s;
  logic [3:0]  flt_cnt;
  logic [2:0]  state;
  logic [3:0]  word_idx;
  logic [23:0] addr_r;
  logic        accept;
  logic [15:0] word;
  logic [15:0] send_word;

  // The counter holds MIN_CNT-1 while the MIN_PULSE-th synchronised high is
  // being presented, so acceptance fires exactly once per qualifying pulse;
  // saturation then blocks a second acceptance until req_s drops.
  assign accept = (state == S_IDLE) && req_s && (flt_cnt == MIN_CNT - 4'd1);

  // NOTE: all state lives in one async-reset block using non-blocking
  // assignments, so every flop samples pre-edge values and reset acts at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_m    <= 1'b0;
      req_s    <= 1'b0;
      flt_cnt  <= 4'd0;
      state    <= S_IDLE;
      word_idx <= 4'd0;
      addr_r   <= 24'h000000;
    end else begin
      req_m <= reboot_req;
      req_s <= req_m;

      // Filter only runs in IDLE; requests seen later are discarded.
      if (state != S_IDLE || !req_s) begin
        flt_cnt <= 4'd0;
      end else if (flt_cnt != MIN_CNT) begin
        flt_cnt <= flt_cnt + 4'd1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_r <= boot_addr;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          word_idx <= 4'd0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (word_idx == LAST_IDX) begin
            word_idx <= 4'd0;
            state    <= S_CLOSE;
          end else begin
            word_idx <= word_idx + 4'd1;
          end
        end
        S_CLOSE: state <= S_DONE;
        S_DONE:  state <= S_DONE;  // terminal: the FPGA reconfigures
        default: state <= S_IDLE;
      endcase
    end
  end

  // IPROG command stream: sync, then GENERAL1..4 (multiboot and fallback
  // addresses with the flash read opcode), then CMD=IPROG and a NOOP.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    word = 16'hFFFF;
    case (word_idx)
      4'd0:    word = 16'hFFFF;
      4'd1:    word = 16'hAA99;
      4'd2:    word = 16'h5566;
      4'd3:    word = 16'h3261;
      4'd4:    word = addr_r[15:0];
      4'd5:    word = 16'h3281;
      4'd6:    word = {SPI_OPCODE, addr_r[23:16]};
      4'd7:    word = 16'h32A1;
      4'd8:    word = FALLBACK_ADDR[15:0];
      4'd9:    word = 16'h32C1;
      4'd10:   word = {SPI_OPCODE, FALLBACK_ADDR[23:16]};
      4'd11:   word = 16'h30A1;
      4'd12:   word = 16'h000E;
      4'd13:   word = 16'h2000;
      default: word = 16'hFFFF;
    endcase
  end

`ifdef ICAP_BITSWAP_EN
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign send_word = {rev8(word[15:8]), rev8(word[7:0])};
`else
  assign send_word = word;
`endif

  // Write enable leads chip enable by one cycle and trails it by one cycle.
  always_comb begin
    icap_ce_n = 1'b1;
    icap_we_n = 1'b1;
    icap_o    = 16'hFFFF;
    case (state)
      S_SETUP: icap_we_n = 1'b0;
      S_SEND: begin
        icap_ce_n = 1'b0;
        icap_we_n = 1'b0;
        icap_o    = send_word;
      end
      S_CLOSE: icap_we_n = 1'b0;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_icap_reboot_seq.sv
// -----------------------------------------------------------------------------
// tb_icap_reboot_seq
//   Self-checking bench for icap_reboot_seq. A behavioural model tracks when a
//   request is accepted (counting synchronised high cycles) and how many cycles
//   have elapsed since; the expected bus state follows from that offset and a
//   word table built from the captured address. Directed scenarios are followed
//   by randomised request/address traffic, all compared every cycle.
// -----------------------------------------------------------------------------
module tb_icap_reboot_seq;

  localparam int MIN_PULSE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reboot_req = 1'b0;
  logic [23:0] boot_addr = 24'h000000;
  logic        icap_ce_n;
  logic        icap_we_n;
  logic [15:0] icap_o;
  logic        busy;

  always #5 clk = ~clk;

  icap_reboot_seq #(
    .MIN_PULSE    (MIN_PULSE),
    .SPI_OPCODE   (8'h0B),
    .FALLBACK_ADDR(24'h000000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reboot_req(reboot_req),
    .boot_addr (boot_addr),
    .icap_ce_n (icap_ce_n),
    .icap_we_n (icap_we_n),
    .icap_o    (icap_o),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] bus_form(input logic [15:0] w);
`ifdef ICAP_BITSWAP_EN
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8 + i] = w[15-i];
    end
    return r;
`else
    return w;
`endif
  endfunction

  logic [1:0]  m_pipe;     // raw request as seen through two sync stages
  int          m_run;      // consecutive synchronised highs while idle
  bit          m_acc;      // request accepted since last reset
  int          m_k;        // cycles since the acceptance edge
  logic [15:0] m_words[14];
  logic [15:0] ce_q[$];
  bit          capture = 1'b0;

  task automatic build_words(input logic [23:0] a);
    logic [15:0] raw [14];
    raw = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, a[15:0], 16'h3281,
            {8'h0B, a[23:16]}, 16'h32A1, 16'h0000, 16'h32C1, 16'h0B00,
            16'h30A1, 16'h000E, 16'h2000};
    for (int i = 0; i < 14; i++) m_words[i] = bus_form(raw[i]);
  endtask

  task automatic model_reset();
    m_pipe = 2'b00;
    m_run  = 0;
    m_acc  = 1'b0;
    m_k    = 0;
  endtask

  task automatic model_edge();
    if (!m_acc) begin
      m_run = m_pipe[1] ? m_run + 1 : 0;
      if (m_run == MIN_PULSE) begin
        m_acc = 1'b1;
        m_k   = 1;
        build_words(boot_addr);
      end
    end else begin
      m_k++;
    end
    m_pipe = {m_pipe[0], reboot_req};
  endtask

  task automatic check_out(input string tag);
    logic [18:0] exp;
    if (!m_acc)          exp = {1'b0, 1'b1, 1'b1, 16'hFFFF};
    else if (m_k == 1)   exp = {1'b1, 1'b1, 1'b0, 16'hFFFF};
    else if (m_k <= 15)  exp = {1'b1, 1'b0, 1'b0, m_words[m_k-2]};
    else if (m_k == 16)  exp = {1'b1, 1'b1, 1'b0, 16'hFFFF};
    else                 exp = {1'b1, 1'b1, 1'b1, 16'hFFFF};
    check(tag, {13'd0, busy, icap_ce_n, icap_we_n, icap_o}, {13'd0, exp});
  endtask

  // One clock: model follows the rising edge, outputs compared at the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out(tag);
    if (capture && !icap_ce_n) ce_q.push_back(icap_o);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    check("reset_now", {13'd0, busy, icap_ce_n, icap_we_n, icap_o},
          {13'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF});
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] lit[14];

  initial begin
    model_reset();
    @(negedge clk);

    // Scenario 1: clean request, literal stream check.
    reset_dut();
    boot_addr = 24'h058000;
    steps("s1_idle", 3);
    ce_q.delete();
    capture = 1'b1;
    reboot_req = 1'b1;
    steps("s1_req", 10);
    reboot_req = 1'b0;
    steps("s1_run", 20);
    capture = 1'b0;
`ifdef ICAP_BITSWAP_EN
    lit = '{16'hFFFF, 16'h5599, 16'hAA66, 16'h4C86, 16'h0100, 16'h4C81, 16'hD0A0,
            16'h4C85, 16'h0000, 16'h4C83, 16'hD000, 16'h0C85, 16'h0070, 16'h0400};
`else
    lit = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h3261, 16'h8000, 16'h3281, 16'h0B05,
            16'h32A1, 16'h0000, 16'h32C1, 16'h0B00, 16'h30A1, 16'h000E, 16'h2000};
`endif
    check("s1_len", ce_q.size(), 14);
    for (int i = 0; i < 14; i++)
      check($sformatf("s1_word%0d", i), (ce_q.size() > i) ? ce_q[i] : 16'hxxxx, lit[i]);

    // Second request while DONE: no ICAP activity, busy held.
    ce_q.delete();
    capture = 1'b1;
    reboot_req = 1'b1;
    steps("done_req", 10);
    reboot_req = 1'b0;
    steps("done_idle", 5);
    capture = 1'b0;
    check("done_no_ce", ce_q.size(), 0);
    check("done_busy", busy, 1'b1);

    // Scenario 2: pulse one cycle too short.
    reset_dut();
    reboot_req = 1'b1;
    steps("short_req", MIN_PULSE - 1);
    reboot_req = 1'b0;
    steps("short_idle", 10);
    check("short_busy", busy, 1'b0);
    check("short_ce", icap_ce_n, 1'b1);

    // Scenario 3: boot_addr changes during SEND index 2.
    reset_dut();
    boot_addr = 24'h058000;
    ce_q.delete();
    capture = 1'b1;
    reboot_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) reboot_req = 1'b0;
      step("s3_run");
      if (m_acc && m_k == 4) boot_addr = 24'h0A0000;
    end
    capture = 1'b0;
    check("s3_len", ce_q.size(), 14);
    check("s3_word4", (ce_q.size() > 4) ? ce_q[4] : 16'hxxxx, bus_form(16'h8000));
    check("s3_word6", (ce_q.size() > 6) ? ce_q[6] : 16'hxxxx, bus_form(16'h0B05));

    // Scenario 4: reset at SEND index 7, then a fresh request.
    reset_dut();
    boot_addr = 24'($urandom);
    reboot_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step("s4_run");
      if (m_acc) reboot_req = 1'b0;
      if (m_acc && m_k == 9) break;
    end
    check("s4_reach", m_k, 9);
    reset_dut();
    ce_q.delete();
    capture = 1'b1;
    reboot_req = 1'b1;
    steps("s4_req", 8);
    reboot_req = 1'b0;
    steps("s4_run2", 20);
    capture = 1'b0;
    check("s4_len", ce_q.size(), 14);
    check("s4_first", (ce_q.size() > 0) ? ce_q[0] : 16'hxxxx, 16'hFFFF);

    // Request pulse coinciding with reset release: not accepted.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reboot_req = 1'b1;
    step("rel_pulse");
    reboot_req = 1'b0;
    steps("rel_idle", 10);
    check("rel_busy", busy, 1'b0);

    // Randomised traffic against the model.
    for (int r = 0; r < 8; r++) begin
      reset_dut();
      boot_addr = 24'($urandom);
      for (int i = 0; i < 60; i++) begin
        reboot_req = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) boot_addr = 24'($urandom);
        step("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
